// File: rtl/i2c_burst_master.sv
// i2c_burst_master: open-drain I2C register burst master (write / combined read), quarter-bit timed.
// Define I2C_CLK_STRETCH_EN to stall the quarter counter while a target holds scl low.
module i2c_burst_master #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BUS_FREQ = 200_000,
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter int MAX_BYTES = 4,
  localparam int NBW = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rw,
  input  logic [7:0]             reg_addr,
  input  logic [NBW-1:0]         num_bytes,
  input  logic [8*MAX_BYTES-1:0] wdata,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  inout  wire                    scl,
  inout  wire                    sda
);
  localparam int QTR = CLK_FREQ / (4 * BUS_FREQ) > 0 ? CLK_FREQ / (4 * BUS_FREQ) : 1;
  localparam int QW = QTR > 1 ? $clog2(QTR) : 1;
  typedef enum logic [3:0] {IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D,
                            RSTART, ADDR_R, ACK_B, RDATA, MACK, STOP, BUS_FREE} state_t;
  state_t state, nxt;
  logic [QW-1:0] qcnt;
  logic [1:0] q;
  logic [2:0] bitcnt;
  logic [NBW-1:0] idx, nb;
  logic [7:0] tx, rx, reg_r;
  logic [8*MAX_BYTES-1:0] wbuf, rbuf;
  logic rw_r, nack, err, scl_low, sda_low, hold, tick, bit_end, last, is_byte, is_ack, accept;
  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;
`ifdef I2C_CLK_STRETCH_EN
  assign hold = state != IDLE && !scl_low && !scl;
`else
  assign hold = 1'b0;
`endif
  assign tick = qcnt == QW'(QTR - 1) && !hold;
  assign bit_end = tick && q == 2'd3;
  assign last = idx == nb - 1'b1;
  assign is_ack = state inside {ACK_A, ACK_R, ACK_D, ACK_B};
  assign is_byte = state inside {ADDR_W, REG, WDATA, ADDR_R, RDATA};
  assign accept = state == IDLE && start && !busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (accept)
      nxt = (num_bytes == '0 || num_bytes > NBW'(MAX_BYTES)) ? IDLE : START;
    else if (bit_end)
      case (state)
        START:    nxt = ADDR_W;
        ADDR_W:   nxt = bitcnt == 3'd7 ? ACK_A : ADDR_W;
        ACK_A:    nxt = nack ? STOP : REG;
        REG:      nxt = bitcnt == 3'd7 ? ACK_R : REG;
        ACK_R:    nxt = nack ? STOP : rw_r ? RSTART : WDATA;
        WDATA:    nxt = bitcnt == 3'd7 ? ACK_D : WDATA;
        ACK_D:    nxt = nack || last ? STOP : WDATA;
        RSTART:   nxt = ADDR_R;
        ADDR_R:   nxt = bitcnt == 3'd7 ? ACK_B : ADDR_R;
        ACK_B:    nxt = nack ? STOP : RDATA;
        RDATA:    nxt = bitcnt == 3'd7 ? MACK : RDATA;
        MACK:     nxt = last ? STOP : RDATA;
        STOP:     nxt = BUS_FREE;
        BUS_FREE: nxt = IDLE;
        default:  nxt = state;
      endcase
  end
  // quarters: 0 sda change (scl low), 1-2 scl high (sample at 1->2), 3 scl low
  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    if (state inside {START, RSTART}) begin
      scl_low = q == 2'd3 || (state == RSTART && q == 2'd0);
      sda_low = q[1];
    end else if (state == STOP) begin
      scl_low = q == 2'd0;
      sda_low = !q[1];
    end else if (is_byte || is_ack || state == MACK) begin
      scl_low = q == 2'd0 || q == 2'd3;
      sda_low = state == MACK ? !last : is_byte && state != RDATA && !tx[7];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {qcnt, q, bitcnt, idx, nb, tx, rx, reg_r} <= '0;
      {wbuf, rbuf, rdata} <= '0;
      {rw_r, nack, err, busy, done, error} <= '0;
    end else begin
      done <= 1'b0;
      error <= 1'b0;
      if (accept) begin
        busy <= 1'b1;
        error <= nxt == IDLE;
        {qcnt, q, bitcnt, idx, err} <= '0;
        nb <= num_bytes;
        rw_r <= rw;
        reg_r <= reg_addr;
        wbuf <= wdata;
        rbuf <= '0;
      end else if (done || error) busy <= 1'b0;
      if (state != IDLE && !hold) begin
        qcnt <= tick ? '0 : qcnt + 1'b1;
        if (tick) q <= q + 1'b1;
      end
      if (state != IDLE && tick && q == 2'd1) begin
        nack <= sda;
        rx <= {rx[6:0], sda};
      end
      if (bit_end) begin
        bitcnt <= nxt == state ? bitcnt + 1'b1 : 3'd0;
        tx <= nxt == state ? {tx[6:0], 1'b0} : nxt == ADDR_W ? {DEV_ADDR, 1'b0} :
              nxt == ADDR_R ? {DEV_ADDR, 1'b1} : nxt == REG ? reg_r : wbuf[7:0];
        if (nxt == WDATA && state != WDATA) wbuf <= wbuf >> 8;
        if (state inside {ACK_D, MACK} && nxt != STOP) idx <= idx + 1'b1;
        if (is_ack && nack) err <= 1'b1;
        if (state == RDATA && bitcnt == 3'd7)
          for (int k = 0; k < MAX_BYTES; k++)
            if (idx == NBW'(k)) rbuf[8*k +: 8] <= rx;
        if (state == BUS_FREE) begin
          done <= !err;
          error <= err;
          if (!err && rw_r) rdata <= rbuf;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_burst_master.sv
// tb_i2c_burst_master: randomized transactions against an ADT7420-like target on pulled-up lines,
// with expected read data taken from a register image the bench maintains itself.
module tb_i2c_burst_master;
  localparam int MB = 4;
  localparam int NBW = $clog2(MB + 1);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0;
  logic [7:0] reg_addr = '0;
  logic [NBW-1:0] num_bytes = '0;
  logic [8*MB-1:0] wdata = '0;
  logic [8*MB-1:0] rdata;
  logic busy, done, error;
  wire scl, sda;
  logic s_low = 1'b0;
  pullup (scl);
  pullup (sda);
  assign sda = s_low ? 1'b0 : 1'bz;
  i2c_burst_master #(.CLK_FREQ(100_000_000), .BUS_FREQ(5_000_000), .DEV_ADDR(7'h4B), .MAX_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .reg_addr(reg_addr), .num_bytes(num_bytes),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .error(error), .scl(scl), .sda(sda));
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  typedef enum {T_IDLE, T_RX, T_ACK, T_TX, T_MACK} tgt_t;
  tgt_t sp = T_IDLE;
  int bn = 0, kind = 0, stop_cnt = 0, mack_cnt = 0, mnack_cnt = 0, low_cnt = 0;
  logic [7:0] sh = '0, ptr = '0;
  logic [6:0] m_addr = 7'h4B;
  logic rd = 1'b0, mk = 1'b0, pscl = 1'b1, psda = 1'b1;
  logic [7:0] regs [256];
  logic [7:0] img [256];
  // target model: acts on scl edges and start/stop conditions seen at each falling clk edge
  always @(negedge clk) begin
    logic c, d;
    c = scl;
    d = sda;
    if (c === 1'b0 || d === 1'b0) low_cnt++;
    if (rst) begin
      sp = T_IDLE;
      s_low = 1'b0;
    end else if (pscl && c && psda && !d) begin
      sp = T_RX; bn = 0; kind = 0;
    end else if (pscl && c && !psda && d) begin
      sp = T_IDLE; s_low = 1'b0; stop_cnt++;
    end else if (!pscl && c) begin
      if (sp == T_RX) begin sh = {sh[6:0], d}; bn++; end
      else if (sp == T_MACK) mk = d;
    end else if (pscl && !c) begin
      case (sp)
        T_RX: if (bn == 8) begin
          if (kind == 0 && sh[7:1] != m_addr) sp = T_IDLE;
          else begin
            s_low = 1'b1;
            sp = T_ACK;
            if (kind == 0) rd = sh[0];
            else if (kind == 1) ptr = sh;
            else begin regs[ptr] = sh; ptr++; end
          end
        end
        T_ACK: begin
          s_low = 1'b0;
          bn = 0;
          if (kind == 0 && rd) begin
            sp = T_TX; sh = regs[ptr]; ptr++; s_low = !sh[7];
          end else begin
            sp = T_RX; kind = kind == 0 ? 1 : 2;
          end
        end
        T_TX: begin
          bn++;
          if (bn == 8) begin s_low = 1'b0; sp = T_MACK; end
          else begin sh = {sh[6:0], 1'b0}; s_low = !sh[7]; end
        end
        T_MACK: if (!mk) begin
          mack_cnt++; sp = T_TX; bn = 0; sh = regs[ptr]; ptr++; s_low = !sh[7];
        end else begin
          mnack_cnt++; sp = T_IDLE;
        end
        default: sp = T_IDLE;
      endcase
    end
    pscl = c;
    psda = d;
  end
  function automatic logic [8*MB-1:0] exp_read(input logic [7:0] ra, input int n);
    exp_read = '0;
    for (int k = 0; k < n; k++) exp_read[8*k +: 8] = img[8'(ra + k)];
  endfunction
  task automatic issue(input logic r, input logic [7:0] ra, input int n, input logic [8*MB-1:0] wd);
    @(negedge clk);
    rw = r; reg_addr = ra; num_bytes = NBW'(n); wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask
  task automatic wait_end(output logic d, output logic e);
    int t;
    t = 0;
    while (!(done || error) && t < 20000) begin @(negedge clk); t++; end
    check("txn_in_time", t < 20000, 1);
    d = done;
    e = error;
    check("busy_at_pulse", busy, 1);
    @(negedge clk);
    check("busy_after_pulse", busy, 0);
    check("pulse_single", done | error, 0);
  endtask
  task automatic run(input logic r, input logic [7:0] ra, input int n, input logic [8*MB-1:0] wd,
                     output logic d, output logic e);
    issue(r, ra, n, wd);
    wait_end(d, e);
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    logic d, e;
    int s0, a0, n0, l0, n, t;
    logic r;
    logic [7:0] ra, v;
    logic [31:0] wd, prev, nbv;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      regs[i] = v;
      img[i] = v;
    end
    regs[8'h0B] = 8'hCB;
    img[8'h0B] = 8'hCB;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rdata", rdata, 0);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    rst = 1'b0;
    // nobody answers the address: STOP, error, rdata untouched
    m_addr = 7'h48;
    s0 = stop_cnt;
    run(1'b1, 8'h0B, 2, '0, d, e);
    check("nack_done", d, 0);
    check("nack_error", e, 1);
    check("nack_rdata", rdata, 0);
    check("nack_stop", stop_cnt - s0, 1);
    m_addr = 7'h4B;
    // device ID read
    s0 = stop_cnt; a0 = mack_cnt; n0 = mnack_cnt;
    run(1'b1, 8'h0B, 1, '0, d, e);
    check("id_done", d, 1);
    check("id_error", e, 0);
    check("id_rdata", rdata, 32'h0000_00CB);
    check("id_macks", mack_cnt - a0, 0);
    check("id_mnacks", mnack_cnt - n0, 1);
    check("id_stop", stop_cnt - s0, 1);
    // temperature MSB/LSB
    a0 = mack_cnt; n0 = mnack_cnt;
    run(1'b1, 8'h00, 2, '0, d, e);
    check("temp_done", d, 1);
    check("temp_rdata", rdata, exp_read(8'h00, 2));
    check("temp_macks", mack_cnt - a0, 1);
    check("temp_mnacks", mnack_cnt - n0, 1);
    // config write then read back
    run(1'b0, 8'h03, 1, 32'h80, d, e);
    img[8'h03] = 8'h80;
    check("cfg_wr_done", d, 1);
    check("cfg_wr_error", e, 0);
    run(1'b1, 8'h03, 1, '0, d, e);
    check("cfg_rd_done", d, 1);
    check("cfg_rd_error", e, 0);
    check("cfg_rd_rdata", rdata, 32'h80);
    // illegal byte counts: one-cycle error, lines untouched
    for (int j = 0; j < 2; j++) begin
      nbv = j == 0 ? 0 : MB + 1;
      prev = rdata;
      l0 = low_cnt;
      @(negedge clk);
      rw = 1'b1; reg_addr = 8'h0B; num_bytes = NBW'(nbv); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("badn_error", error, 1);
      check("badn_busy", busy, 1);
      check("badn_done", done, 0);
      @(negedge clk);
      check("badn_error_off", error, 0);
      check("badn_busy_off", busy, 0);
      repeat (40) @(negedge clk);
      check("badn_no_bus", low_cnt - l0, 0);
      check("badn_rdata", rdata, prev);
    end
    // a start while busy is ignored
    s0 = stop_cnt;
    issue(1'b1, 8'h0B, 1, '0);
    repeat (40) @(negedge clk);
    rw = 1'b0; reg_addr = 8'h10; num_bytes = NBW'(1); wdata = 32'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(d, e);
    check("ign_done", d, 1);
    check("ign_rdata", rdata, 32'hCB);
    repeat (300) @(negedge clk);
    check("ign_one_stop", stop_cnt - s0, 1);
    check("ign_busy", busy, 0);
    check("ign_reg", regs[8'h10], img[8'h10]);
    // reset during read data
    issue(1'b1, 8'h00, MB, '0);
    t = 0;
    while (!(sp == T_TX && bn == 3 && scl === 1'b0) && t < 20000) begin @(negedge clk); t++; end
    check("mid_reach", t < 20000, 1);
    s0 = stop_cnt;
    rst = 1'b1;
    #1;
    check("mid_scl", scl, 1);
    check("mid_busy", busy, 0);
    check("mid_rdata", rdata, 0);
    @(negedge clk);
    check("mid_sda", sda, 1);
    rst = 1'b0;
    l0 = 0;
    repeat (300) begin @(negedge clk); l0 += int'(done | error); end
    check("mid_no_pulse", l0, 0);
    check("mid_no_stop", stop_cnt - s0, 0);
    run(1'b1, 8'h0B, 1, '0, d, e);
    check("post_done", d, 1);
    check("post_rdata", rdata, 32'hCB);
    // random traffic
    for (int i = 0; i < 16; i++) begin
      r = 1'($urandom);
      n = $urandom_range(1, MB);
      ra = r ? 8'($urandom_range(0, 63)) : 8'($urandom_range(16, 63));
      wd = $urandom;
      prev = rdata;
      a0 = mack_cnt; n0 = mnack_cnt;
      run(r, ra, n, wd, d, e);
      check("rnd_done", d, 1);
      check("rnd_error", e, 0);
      if (r) begin
        check("rnd_rdata", rdata, exp_read(ra, n));
        check("rnd_macks", mack_cnt - a0, n - 1);
        check("rnd_mnacks", mnack_cnt - n0, 1);
      end else begin
        for (int k = 0; k < n; k++) img[8'(ra + k)] = wd[8*k +: 8];
        check("rnd_wr_rdata", rdata, prev);
        for (int k = 0; k < n; k++) check("rnd_wr_byte", regs[8'(ra + k)], img[8'(ra + k)]);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/i2c_burst_master.md
I2C_BURST_MASTER -- requirements
Module: i2c_burst_master

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BUS_FREQ, default 200_000, SCL frequency in Hz.
REQ-003 SHALL have parameter DEV_ADDR, default 7'h4B, 7-bit target address.
REQ-004 SHALL have parameter MAX_BYTES, default 4, maximum data bytes per transaction (1..16).
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  single-cycle transaction request.
REQ-008 SHALL have port rw  input  1  1=read, 0=write; sampled with start.
REQ-009 SHALL have port reg_addr  input  8  target register pointer; sampled with start.
REQ-010 SHALL have port num_bytes  input  $clog2(MAX_BYTES+1)  byte count; sampled with start.
REQ-011 SHALL have port wdata  input  8*MAX_BYTES  write bytes, byte k at [8k+7:8k]; sampled with start.
REQ-012 SHALL have port rdata  output  8*MAX_BYTES  read bytes, byte k at [8k+7:8k].
REQ-013 SHALL have ports busy, done, error  output  1 each  status; done/error are single-cycle pulses.
REQ-014 SHALL have ports scl, sda  inout  1 each  open-drain: drive 0 or Z only, never 1.

Function
REQ-015 SHALL derive quarter-bit tick QTR = CLK_FREQ/(4*BUS_FREQ) cycles; each SCL bit = 4 quarters (SDA change, SCL rise, sample at mid-high, SCL fall).
REQ-016 SHALL implement states IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D, RSTART, ADDR_R, ACK_B, RDATA, MACK, STOP, BUS_FREE.
REQ-017 Write: START, DEV_ADDR+0, reg_addr, num_bytes data bytes LSB-index first, each byte MSB first, STOP.
REQ-018 Read: START, DEV_ADDR+0, reg_addr, repeated START, DEV_ADDR+1, num_bytes bytes; master ACK all but last, NACK last, STOP.
REQ-019 SHALL assert busy the cycle after accepted start until the done/error pulse cycle inclusive.
REQ-020 SHALL ignore start while busy.
REQ-021 num_bytes=0 or >MAX_BYTES: error pulse 1 cycle after start, busy for that cycle only, no bus activity.
REQ-022 NACK at any ACK_* state: generate STOP, then error pulse; rdata unchanged.
REQ-023 rdata SHALL update only when the full read completes, same cycle as done; unread upper bytes cleared to 0.
REQ-024 BUS_FREE SHALL hold both lines released ≥4 quarters after STOP before done/error and return to IDLE.
REQ-025 SHALL sample sda only at mid-high quarter of SCL.

Reset
REQ-026 rst SHALL immediately force IDLE, busy=0, done=0, error=0, rdata=0, scl=Z, sda=Z.
REQ-027 Reset mid-transaction SHALL release lines without generating STOP; no done/error pulse.

Configuration
REQ-028 Macro I2C_CLK_STRETCH_EN defined: after each SCL release, quarter counter SHALL hold until scl reads 1 (target clock stretching honoured).
REQ-029 Macro I2C_CLK_STRETCH_EN undefined: scl readback SHALL be ignored; timing purely counter-driven.

Verification (pullups on scl/sda, ADT7420 model at 0x4B)
REQ-030 Read reg 0x0B, num_bytes=1 -> rdata[7:0]=0xCB, done pulse, master NACK on byte 0, STOP seen.
REQ-031 Read reg 0x00, num_bytes=2 -> rdata[7:0]=temp MSB, rdata[15:8]=temp LSB matching model, ACK after byte 0, NACK after byte 1.
REQ-032 Write reg 0x03 num_bytes=1 wdata=0x80, then read 0x03 -> second rdata[7:0]=0x80, two done pulses, no error.
REQ-033 DEV_ADDR=7'h48 vs model at 0x4B -> NACK on address, STOP generated, error pulse, no done, rdata=0.
REQ-034 num_bytes=0 -> error pulse next cycle, scl and sda never driven low.
REQ-035 rst asserted mid-RDATA -> scl/sda Z same cycle, busy=0; subsequent read of 0x0B completes with 0xCB.
